// File: rtl/game_controller.sv
// Round sequencer: IDLE -> READY countdown -> PLAY -> OVER, with a saturating
// two-digit BCD score and a session best score. Every output is registered.
module game_controller #(
    parameter int unsigned READY_SECS   = 3,
    parameter int unsigned MISS_PENALTY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       start_btn,
    input  logic       hit,
    input  logic       miss,
    input  logic       time_up,
    output logic       in_game,
    output logic       timer_rst_n,
    output logic [1:0] state,
    output logic [3:0] ready_cnt,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] best_tens,
    output logic [3:0] best_ones,
    output logic       new_best
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        PLAY  = 2'b10,
        OVER  = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam logic [3:0] READY_INIT = 4'(READY_SECS);
    localparam logic [3:0] PENALTY    = 4'(MISS_PENALTY);

    state_t     state_q, state_d;
    logic       start_q;
    logic       start_edge;
    logic [3:0] ready_q, ready_d;
    bcd2_t      score_q, score_d, score_play;
    bcd2_t      best_q, best_d;
    logic       new_best_q, new_best_d;
    logic       in_game_q, in_game_d;
    logic       timer_rst_n_q, timer_rst_n_d;

    // +1 with carry between digits, holding at 99.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones != 4'd9) begin
            r.ones = v.ones + 4'd1;
        end else if (v.tens != 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end
        return r;
    endfunction

    // Subtract a single digit with borrow from tens, clamping at 00.
    function automatic bcd2_t bcd_sub(input bcd2_t v, input logic [3:0] p);
        bcd2_t r;
        r = v;
        if (v.ones >= p) begin
            r.ones = v.ones - p;
        end else if (v.tens == 4'd0) begin
            r = '0;
        end else begin
            r.ones = v.ones + 4'd10 - p;
            r.tens = v.tens - 4'd1;
        end
        return r;
    endfunction

    function automatic logic bcd_gt(input bcd2_t a, input bcd2_t b);
        return (a.tens > b.tens) || ((a.tens == b.tens) && (a.ones > b.ones));
    endfunction

    assign start_edge = start_btn & ~start_q;

    always_comb begin
        score_play = score_q;
        if (hit && !miss) begin
            score_play = bcd_inc(score_q);
        end else if (miss && !hit) begin
            score_play = bcd_sub(score_q, PENALTY);
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        ready_d       = ready_q;
        score_d       = score_q;
        best_d        = best_q;
        new_best_d    = new_best_q;
        timer_rst_n_d = 1'b1;

        unique case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_d       = READY;
                    score_d       = '0;
                    new_best_d    = 1'b0;
                    ready_d       = READY_INIT;
                    timer_rst_n_d = 1'b0;
                end
            end
            READY: begin
                if (tick_1hz) begin
                    // Zero is unreachable; treating it as final keeps the FSM from sticking.
                    if (ready_q <= 4'd1) begin
                        state_d = PLAY;
                        ready_d = 4'd0;
                    end else begin
                        ready_d = ready_q - 4'd1;
                    end
                end
            end
            PLAY: begin
                score_d = score_play;
                if (time_up) begin
                    state_d = OVER;
                    if (bcd_gt(score_play, best_q)) begin
                        best_d     = score_play;
                        new_best_d = 1'b1;
                    end else begin
                        new_best_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_game_d = (state_d == PLAY);
    end

    // NOTE: every register has an async reset value and is updated with <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            ready_q       <= 4'd0;
            score_q       <= '0;
            best_q        <= '0;
            new_best_q    <= 1'b0;
            in_game_q     <= 1'b0;
            timer_rst_n_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            start_q       <= start_btn;
            ready_q       <= ready_d;
            score_q       <= score_d;
            best_q        <= best_d;
            new_best_q    <= new_best_d;
            in_game_q     <= in_game_d;
            timer_rst_n_q <= timer_rst_n_d;
        end
    end

    assign state       = state_q;
    assign in_game     = in_game_q;
    assign timer_rst_n = timer_rst_n_q;
    assign ready_cnt   = ready_q;
    assign score_tens  = score_q.tens;
    assign score_ones  = score_q.ones;
    assign best_tens   = best_q.tens;
    assign best_ones   = best_q.ones;
    assign new_best    = new_best_q;

    // Output relationships that must hold whenever the block is out of reset.
    a_in_game_only_play : assert property (@(posedge clk) disable iff (rst)
        in_game == (state_q == PLAY));
    a_ready_cnt_only_ready : assert property (@(posedge clk) disable iff (rst)
        (ready_q != 4'd0) |-> (state_q == READY));
    a_timer_pulse_in_ready : assert property (@(posedge clk) disable iff (rst)
        !timer_rst_n |-> (state_q == READY));
    a_digits_are_bcd : assert property (@(posedge clk) disable iff (rst)
        (score_q.tens <= 4'd9) && (score_q.ones <= 4'd9) &&
        (best_q.tens <= 4'd9) && (best_q.ones <= 4'd9));

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: each scenario pushes the expected output
// snapshot when it drives a cycle and pops/compares it once the DUT has clocked.
module tb_game_controller;

    localparam int READY_SECS   = 3;
    localparam int MISS_PENALTY = 1;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_READY = 2'b01;
    localparam logic [1:0] S_PLAY  = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       start_btn;
    logic       hit;
    logic       miss;
    logic       time_up;
    logic       in_game;
    logic       timer_rst_n;
    logic [1:0] state;
    logic [3:0] ready_cnt;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [3:0] best_tens;
    logic [3:0] best_ones;
    logic       new_best;

    game_controller #(
        .READY_SECS  (READY_SECS),
        .MISS_PENALTY(MISS_PENALTY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .start_btn  (start_btn),
        .hit        (hit),
        .miss       (miss),
        .time_up    (time_up),
        .in_game    (in_game),
        .timer_rst_n(timer_rst_n),
        .state      (state),
        .ready_cnt  (ready_cnt),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .best_tens  (best_tens),
        .best_ones  (best_ones),
        .new_best   (new_best)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       ig;
        logic       trn;
        logic [3:0] rc;
        logic [7:0] sc;
        logic [7:0] bs;
        logic       nb;
    } snap_t;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Expected round state, advanced by the scenarios in decimal terms.
    logic [1:0] e_state;
    logic       e_ig, e_trn, e_nb;
    int         e_ready, e_score, e_best;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic snap_t expected();
        snap_t s;
        s.st  = e_state;
        s.ig  = e_ig;
        s.trn = e_trn;
        s.rc  = 4'(e_ready);
        s.sc  = to_bcd(e_score);
        s.bs  = to_bcd(e_best);
        s.nb  = e_nb;
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.st  = state;
        s.ig  = in_game;
        s.trn = timer_rst_n;
        s.rc  = ready_cnt;
        s.sc  = {score_tens, score_ones};
        s.bs  = {best_tens, best_ones};
        s.nb  = new_best;
        return s;
    endfunction

    function automatic string show(input snap_t s);
        return $sformatf("state=%0d in_game=%0b timer_rst_n=%0b ready=%0d score=%h best=%h new_best=%0b",
                         s.st, s.ig, s.trn, s.rc, s.sc, s.bs, s.nb);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_expect();
        e_state = S_IDLE;
        e_ig    = 1'b0;
        e_trn   = 1'b1;
        e_ready = 0;
        e_score = 0;
        e_best  = 0;
        e_nb    = 1'b0;
    endtask

    function automatic int apply_score(input int s, input bit h, input bit m);
        if (h && !m) return (s < 99) ? s + 1 : 99;
        if (m && !h) return (s >= MISS_PENALTY) ? s - MISS_PENALTY : 0;
        return s;
    endfunction

    task automatic test_reset();
        snap_t got, want;
        rst = 1'b1; tick_1hz = 1'b0; start_btn = 1'b0;
        hit = 1'b0; miss = 1'b0; time_up = 1'b0;
        repeat (2) cyc();
        set_reset_expect();
        exp_q.push_back(expected());
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_state: got {%s} expected {%s}", show(got), show(want));
        end
        rst = 1'b0;
        exp_q.push_back(expected());
        cyc();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL idle_after_reset: got {%s} expected {%s}", show(got), show(want));
        end
    endtask

    // Press start, then run the countdown with hits and a miss that must be ignored.
    task automatic start_round(input string tag, input bit hold);
        snap_t got, want;
        start_btn = 1'b1; hit = 1'b0; miss = 1'b0; tick_1hz = 1'b0;
        e_state = S_READY; e_score = 0; e_nb = 1'b0;
        e_ready = READY_SECS; e_trn = 1'b0; e_ig = 1'b0;
        exp_q.push_back(expected());
        cyc();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s_ready_entry: got {%s} expected {%s}", tag, show(got), show(want));
        end
        if (!hold) start_btn = 1'b0;
        time_up = 1'b0;
        e_trn   = 1'b1;
        exp_q.push_back(expected());
        cyc();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s_timer_pulse_end: got {%s} expected {%s}", tag, show(got), show(want));
        end
        for (int k = READY_SECS; k >= 1; k--) begin
            hit = 1'b1; tick_1hz = 1'b0;
            exp_q.push_back(expected());
            cyc();
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s_no_tick_%0d: got {%s} expected {%s}", tag, k, show(got), show(want));
            end
            tick_1hz = 1'b1; hit = 1'b1; miss = (k == 2);
            if (k == 1) begin
                e_state = S_PLAY; e_ready = 0; e_ig = 1'b1;
            end else begin
                e_ready = k - 1;
            end
            exp_q.push_back(expected());
            cyc();
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s_tick_%0d: got {%s} expected {%s}", tag, READY_SECS - k + 1,
                         show(got), show(want));
            end
            tick_1hz = 1'b0; hit = 1'b0; miss = 1'b0;
        end
    endtask

    // n cycles of the given hit/miss levels; tick_1hz toggles randomly and must not matter.
    task automatic play_events(input string tag, input int n, input bit h, input bit m);
        snap_t got, want;
        for (int i = 0; i < n; i++) begin
            hit = h; miss = m; tick_1hz = 1'($urandom_range(0, 1));
            if (e_state == S_PLAY) e_score = apply_score(e_score, h, m);
            exp_q.push_back(expected());
            cyc();
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s[%0d]: got {%s} expected {%s}", tag, i, show(got), show(want));
            end
        end
        hit = 1'b0; miss = 1'b0; tick_1hz = 1'b0;
    endtask

    // Raise time_up (held afterwards, as the real timer does) with an optional same-cycle event.
    task automatic end_round(input string tag, input bit h, input bit m);
        snap_t got, want;
        time_up = 1'b1; hit = h; miss = m;
        e_score = apply_score(e_score, h, m);
        e_state = S_OVER; e_ig = 1'b0;
        if (e_score > e_best) begin
            e_best = e_score; e_nb = 1'b1;
        end else begin
            e_nb = 1'b0;
        end
        exp_q.push_back(expected());
        cyc();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s_over: got {%s} expected {%s}", tag, show(got), show(want));
        end
        hit = 1'b0; miss = 1'b0;
        exp_q.push_back(expected());
        cyc();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s_over_hold: got {%s} expected {%s}", tag, show(got), show(want));
        end
    endtask

    task automatic test_ready_countdown();
        start_round("r1", 1'b0);
    endtask

    task automatic test_async_reset();
        snap_t got, want;
        play_events("r1_hits", 12, 1'b1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        set_reset_expect();
        exp_q.push_back(expected());
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_reset_mid_play: got {%s} expected {%s}", show(got), show(want));
        end
        #2 rst = 1'b0;
        exp_q.push_back(expected());
        cyc();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL idle_after_async_reset: got {%s} expected {%s}", show(got), show(want));
        end
    endtask

    task automatic test_play_scoring();
        start_round("r2", 1'b0);
        play_events("miss_at_00", 1, 1'b0, 1'b1);
        play_events("hits_to_09", 9, 1'b1, 1'b0);
        play_events("hit_to_10", 1, 1'b1, 1'b0);
        play_events("miss_borrow", 1, 1'b0, 1'b1);
        play_events("hit_and_miss", 1, 1'b1, 1'b1);
        play_events("misses_to_00", 9, 1'b0, 1'b1);
        play_events("hits_120", 120, 1'b1, 1'b0);
        play_events("misses_to_41", 58, 1'b0, 1'b1);
    endtask

    task automatic test_game_over();
        end_round("r2_hit_with_time_up", 1'b1, 1'b0);
    endtask

    task automatic test_best_retained();
        start_round("r3", 1'b0);
        play_events("r3_hits", 30, 1'b1, 1'b0);
        end_round("r3_lower", 1'b0, 1'b0);
        start_round("r4", 1'b0);
        play_events("r4_hits", 42, 1'b1, 1'b0);
        end_round("r4_equal", 1'b0, 1'b0);
    endtask

    task automatic test_start_hold();
        start_round("r5", 1'b1);
        play_events("r5_play_held", 3, 1'b1, 1'b0);
        start_btn = 1'b0;
        play_events("r5_release", 1, 1'b0, 1'b0);
        start_btn = 1'b1;
        play_events("r5_repress_in_play", 2, 1'b0, 1'b0);
        end_round("r5_held", 1'b0, 1'b0);
        play_events("r5_over_held", 2, 1'b0, 1'b0);
        start_btn = 1'b0;
        play_events("r5_over_release", 1, 1'b0, 1'b0);
        start_round("r6", 1'b0);
    endtask

    initial begin
        test_reset();
        test_ready_countdown();
        test_async_reset();
        test_play_scoring();
        test_game_over();
        test_best_retained();
        test_start_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 20000 clock periods");
        $fatal(1);
    end

endmodule
